pc_sequencer: RTL

- Multi-cycle fetch/decode/execute controller that drives the program counter's select code (PS), its branch offset and the datapath write strobes.
- Sits between instruction memory, the ALU flags and the 6-bit program counter.
- Exactly one PC update per retired instruction; the PC holds (PS=00) in every other cycle.

---
 rtl/pc_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/decode/execute controller.
// Drives the PC select code, the branch offset and the datapath write strobes.
// The PC moves exactly once per retired instruction and holds (PS=00) otherwise.
module pc_sequencer #(
  parameter int IW       = 16,
  parameter int WAIT_MAX = 8
) (
  input  logic          clk_main,
  input  logic          reset,
  input  logic          run,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  input  logic          zero_flag,
  input  logic          neg_flag,
  output logic          imem_req,
  output logic [IW-1:0] IR,
  output logic [1:0]    PS,
  output logic [3:0]    offset,
  output logic          rf_we,
  output logic          mem_we,
  output logic          halted,
  output logic          fault,
  output logic [2:0]    state
);

  localparam int CW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_WB     = 3'b100,
    S_HALT   = 3'b101
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_ir;
  logic [CW-1:0] r_wait_cnt;
  logic          r_run_q;
  logic          r_fault;
  logic          w_run_rise;
  logic [3:0]    w_opcode;

  assign w_run_rise = run & ~r_run_q;
  assign w_opcode   = r_ir[IW-1 -: 4];

  // Delayed copy of run so only a 0->1 edge starts or resumes the sequencer.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) r_run_q <= 1'b0;
    else       r_run_q <= run;
  end

  // Sequencer state, instruction register, fetch wait counter and fault flag.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ir       <= '0;
      r_wait_cnt <= '0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_run_rise) r_state <= S_FETCH;
        end
        S_FETCH: begin
          // An ack in the timeout cycle still completes the fetch.
          if (imem_ack) begin
            r_ir       <= imem_data;
            r_wait_cnt <= '0;
            r_state    <= S_DECODE;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_fault    <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= S_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          case (w_opcode)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: r_state <= S_WB;
            4'hF:                                     r_state <= S_HALT;
            default:                                  r_state <= S_FETCH;
          endcase
        end
        S_WB: r_state <= S_FETCH;
        S_HALT: begin
          if (w_run_rise) begin
            r_fault <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // PC select and write strobes; combinational so reset drops them immediately.
  // NOTE: every output gets a default first so no latch is inferred for unlisted cases.
  always_comb begin
    PS     = 2'b00;
    rf_we  = 1'b0;
    mem_we = 1'b0;
    case (r_state)
      S_EXEC: begin
        case (w_opcode)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: PS = 2'b00;
          4'h8: begin
            mem_we = 1'b1;
            PS     = 2'b01;
          end
          4'h9:    PS = zero_flag ? 2'b10 : 2'b01;
          4'hA:    PS = neg_flag  ? 2'b10 : 2'b01;
          4'hB:    PS = 2'b11;
          default: PS = 2'b01;  // NOP, HALT and unused opcodes step the PC
        endcase
      end
      S_WB: begin
        rf_we = 1'b1;
        PS    = 2'b01;
      end
      default: PS = 2'b00;
    endcase
  end

  assign imem_req = (r_state == S_FETCH);
  assign halted   = (r_state == S_HALT);
  assign IR       = r_ir;
  assign offset   = r_ir[3:0];
  assign fault    = r_fault;
  assign state    = r_state;

endmodule
